// File: rtl/iterative_alu.sv
// Execute-stage ALU: logic, add and LUI complete in one cycle; SLL/SRL run on a
// 1-bit-per-cycle shifter behind a start/busy/done handshake.
module iterative_alu #(
  parameter int unsigned N_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        ALUOperation,
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  input  logic [4:0]        shamt,
  output logic [N_BITS-1:0] ALUResult,
  output logic              Zero,
  output logic              busy,
  output logic              done,
  output logic              invalid_op
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] work;
  logic [N_BITS-1:0] work_next;
  logic [4:0]        cnt;
  logic              shift_right;
  logic [N_BITS-1:0] comb_result;
  logic              comb_invalid;
  logic              is_shift;
  logic              launch_shift;

  assign is_shift     = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
  assign launch_shift = start && is_shift && (shamt != 5'd0);
  assign busy         = (state_q == SHIFT);
  assign work_next    = shift_right ? (work >> 1) : (work << 1);

  // Single-cycle result decode; a shift reaching here has shamt=0, so it passes B through.
  always_comb begin
    comb_result  = '0;
    comb_invalid = 1'b0;
    case (ALUOperation)
      OP_AND:         comb_result = A & B;
      OP_OR:          comb_result = A | B;
      OP_NOR:         comb_result = ~(A | B);
      OP_ADD:         comb_result = A + B;
      OP_LUI:         comb_result = {B[15:0], 16'h0000};
      OP_SLL, OP_SRL: comb_result = B;
      default:        comb_invalid = 1'b1;
    endcase
  end

  // Next-state: enter SHIFT only for a nonzero shift, leave when the last bit moves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch_shift) state_d = SHIFT;
      SHIFT:   if (cnt == 5'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: operand capture, iterative shifting and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResult   <= '0;
      Zero        <= 1'b1;
      done        <= 1'b0;
      invalid_op  <= 1'b0;
      work        <= '0;
      cnt         <= 5'd0;
      shift_right <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (launch_shift) begin
              work        <= B;
              cnt         <= shamt;
              shift_right <= (ALUOperation == OP_SRL);
              invalid_op  <= 1'b0;
            end else begin
              ALUResult  <= comb_result;
              Zero       <= (comb_result == '0);
              invalid_op <= comb_invalid;
              done       <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            ALUResult <= work_next;
            Zero      <= (work_next == '0);
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu using a scoreboard queue of expected completions.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ALUOperation = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] ALUResult;
  logic        Zero, busy, done, invalid_op;

  int unsigned total = 0;
  int unsigned passed = 0;

  typedef struct {
    logic [31:0] res;
    logic        inv;
    int          lat;
  } exp_t;

  exp_t sb[$];

  iterative_alu #(.N_BITS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .shamt(shamt), .ALUResult(ALUResult), .Zero(Zero),
    .busy(busy), .done(done), .invalid_op(invalid_op)
  );

  always #5 clk = ~clk;

  // Reference for single-cycle codes: {invalid, result}.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, ~(a | b)};
      4'b0011: return {1'b0, a + b};
      4'b0101: return {1'b0, b[15:0], 16'h0000};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Drive one request at a negedge, push its expectation, release start after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] er, input logic ei, input int el);
    exp_t e;
    @(negedge clk);
    ALUOperation = op; A = a; B = b; shamt = sh; start = 1'b1;
    e.res = er; e.inv = ei; e.lat = el;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done; report edges after acceptance and cycles seen busy.
  task automatic collect(input bit disturb, output logic [31:0] r, output logic z,
                         output logic iv, output int lat, output int busy_cnt, output bit timeout);
    lat = 0; busy_cnt = 0; timeout = 1'b1;
    r = '0; z = 1'b0; iv = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        timeout = 1'b0;
        r = ALUResult; z = Zero; iv = invalid_op;
        break;
      end
      if (busy) busy_cnt++;
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        A = $urandom; B = $urandom;
        ALUOperation = 4'($urandom_range(0, 15));
        shamt = 5'($urandom_range(0, 31));
      end
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #2;
    total++; if (ALUResult !== 32'h0) $display("FAIL reset_result got=%h exp=%h", ALUResult, 32'h0); else passed++;
    total++; if (Zero !== 1'b1) $display("FAIL reset_zero got=%b exp=1", Zero); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0 || invalid_op !== 1'b0)
      $display("FAIL reset_flags got busy=%b done=%b inv=%b exp=000", busy, done, invalid_op); else passed++;
    #10 reset = 1'b1;
  endtask

  // Assert reset between clock edges and check outputs clear without a clock edge.
  task automatic test_reset_async(input string nm);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (ALUResult !== 32'h0 || Zero !== 1'b1)
      $display("FAIL %s result/zero got=%h/%b exp=00000000/1", nm, ALUResult, Zero); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0 || invalid_op !== 1'b0)
      $display("FAIL %s flags got busy=%b done=%b inv=%b exp=000", nm, busy, done, invalid_op); else passed++;
    #1 reset = 1'b1;
  endtask

  task automatic run_and_score(input string nm, input bit disturb);
    logic [31:0] r; logic z, iv; int lat, bc; bit to; exp_t e;
    collect(disturb, r, z, iv, lat, bc, to);
    e = sb.pop_front();
    total++; if (to) $display("FAIL %s timeout waiting for done", nm); else passed++;
    total++; if (r !== e.res) $display("FAIL %s result got=%h exp=%h", nm, r, e.res); else passed++;
    total++; if (z !== (e.res == 32'h0)) $display("FAIL %s zero got=%b exp=%b", nm, z, e.res == 32'h0); else passed++;
    total++; if (iv !== e.inv) $display("FAIL %s invalid_op got=%b exp=%b", nm, iv, e.inv); else passed++;
    total++; if (lat != e.lat) $display("FAIL %s latency got=%0d exp=%0d", nm, lat, e.lat); else passed++;
    total++; if (bc != e.lat) $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, bc, e.lat); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL %s done_pulse got=%b exp=0", nm, done); else passed++;
  endtask

  task automatic test_single_cycle;
    issue(4'b0000, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'h0000_0000, 1'b0, 0); run_and_score("and", 1'b0);
    issue(4'b0001, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'h0000_0FFF, 1'b0, 0); run_and_score("or", 1'b0);
    issue(4'b0010, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'hFFFF_F000, 1'b0, 0); run_and_score("nor", 1'b0);
    issue(4'b0011, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'h0000_0FFF, 1'b0, 0); run_and_score("add", 1'b0);
    issue(4'b0101, 32'h0000_00F0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 0); run_and_score("lui", 1'b0);
  endtask

  task automatic test_add_wrap;
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0, 0); run_and_score("add_wrap", 1'b0);
  endtask

  task automatic test_sll;
    issue(4'b0110, 32'h0, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0, 4); run_and_score("sll4", 1'b0);
  endtask

  task automatic test_srl_disturb;
    issue(4'b0111, 32'h0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 31); run_and_score("srl31", 1'b1);
  endtask

  task automatic test_shamt_zero;
    issue(4'b0110, 32'h0, 32'hABCD_0000, 5'd0, 32'hABCD_0000, 1'b0, 0); run_and_score("sll0", 1'b0);
  endtask

  task automatic test_invalid;
    issue(4'b1001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'h0000_0000, 1'b1, 0); run_and_score("invalid", 1'b0);
  endtask

  task automatic test_reset_mid_shift;
    int dones = 0;
    @(negedge clk);
    ALUOperation = 4'b0110; A = '0; B = 32'h0000_0003; shamt = 5'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_shift_reset got busy=%b done=%b exp=00", busy, done); else passed++;
    #1 reset = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total++; if (dones != 0) $display("FAIL mid_shift_abandon got=%0d busy/done cycles exp=0", dones); else passed++;
    issue(4'b0011, 32'h0000_0100, 32'h0000_0023, 5'd0, 32'h0000_0123, 1'b0, 0); run_and_score("add_after_reset", 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [3:0] codes[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0100, 4'b1001, 4'b1111};
    logic [32:0] m;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        e = sb.pop_front();
        total++; if (done !== 1'b1) $display("FAIL b2b_done[%0d] got=%b exp=1", i - 1, done); else passed++;
        total++; if (ALUResult !== e.res || invalid_op !== e.inv || Zero !== (e.res == 32'h0))
          $display("FAIL b2b_result[%0d] got=%h/%b/%b exp=%h/%b/%b", i - 1, ALUResult, invalid_op, Zero,
                   e.res, e.inv, e.res == 32'h0); else passed++;
      end
      if (i < 8) begin
        ALUOperation = codes[i]; A = $urandom; B = $urandom; shamt = 5'd0; start = 1'b1;
        if (i == 3) B = 32'h0 - A;
        m = model(ALUOperation, A, B);
        e.res = m[31:0]; e.inv = m[32]; e.lat = 0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL b2b_tail_done got=%b exp=0", done); else passed++;
  endtask

  initial begin
    test_reset;
    test_single_cycle;
    test_add_wrap;
    test_sll;
    test_srl_disturb;
    test_reset_async("reset_after_srl");
    test_shamt_zero;
    test_invalid;
    test_reset_async("reset_after_invalid");
    test_reset_mid_shift;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Execute-stage ALU that directly consumes the 4-bit ALUOperation code from the ALU control decoder, plus operands A/B and the shamt field.
- Logic, add and LUI complete in one cycle.
- SLL/SRL run on a 1-bit-per-cycle iterative shifter, so a shift takes shamt cycles.
- A start/busy/done handshake lets the datapath controller stall while a shift runs.

Parameters:
N_BITS, 32, operand/result width (LUI and shamt rules assume 32)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy=0
ALUOperation  input  4  operation code from ALU control decoder
A  input  N_BITS  operand A (rs)
B  input  N_BITS  operand B (rt or immediate)
shamt  input  5  shift amount (instruction bits 10:6)
ALUResult  output  N_BITS  registered result
Zero  output  1  registered, 1 when ALUResult==0
busy  output  1  high while an iterative shift is in progress
done  output  1  one-cycle pulse when ALUResult/Zero/invalid_op update
invalid_op  output  1  registered, 1 if last accepted code was unsupported

Behaviour:
- Reset (reset=0, asynchronous):
  - ALUResult=0, Zero=1, busy=0, done=0, invalid_op=0.
  - Shift counter=0; state=IDLE.
  - Reset asserted mid-shift abandons the operation; no done is produced.
- States: IDLE, SHIFT.
- Operation codes:
  - 0000 AND A&B
  - 0001 OR A|B
  - 0010 NOR ~(A|B)
  - 0011 ADD A+B, modulo 2^32, no overflow flag
  - 0101 LUI {B[15:0],16'h0000}
  - 0110 SLL B<<shamt
  - 0111 SRL B>>shamt, logical (zero fill)
  - Any other code (including 1001): ALUResult=0, invalid_op=1.
- Rules for IDLE with start=1 at edge k:
  - Non-shift, invalid, or shift with shamt=0: at edge k write ALUResult, Zero and invalid_op. done=1 for cycle k..k+1. Stay IDLE; busy stays 0. Latency 1.
  - Shift with shamt>0:
    - Capture work=B, cnt=shamt, direction from ALUOperation.
    - busy=1; state=SHIFT; invalid_op=0.
    - ALUResult, Zero and done unchanged/0.
- Rules for SHIFT, at each edge:
  - work shifts 1 bit in the captured direction, zero fill; cnt decrements.
  - On the edge where cnt goes 1->0:
    - ALUResult=final shifted value; Zero updated.
    - done=1 for one cycle; busy=0; state=IDLE.
  - Total latency = shamt edges after acceptance (max 31).
- Inputs:
  - Operands, shamt and ALUOperation are sampled only at the accept edge; changes during SHIFT are ignored.
  - start while busy=1 is ignored, not queued. The controller must hold start until it sees busy=0.
- Back-to-back: a start in the cycle where done=1 (busy=0) is accepted. Single-cycle ops can issue every cycle with done high continuously.
- Outputs:
  - ALUResult, Zero and invalid_op hold their last value until the next completion.
  - done is never high for two cycles from one request.
- Zero is always consistent with the ALUResult currently driven.

Test Plan:
- Reset: reset=0 mid-run -> ALUResult=0, Zero=1, busy=0, done=0, invalid_op=0 immediately, without waiting for clk.
- Single-cycle ops, start with A=32'h0000_00F0, B=32'h0000_0F0F:
  - AND(0000) -> 32'h0000_0000, Zero=1
  - OR(0001) -> 32'h0000_0FFF
  - NOR(0010) -> 32'hFFFF_F000
  - ADD(0011) -> 32'h0000_0FFF
  - LUI(0101) with B=32'h0000_1234 -> 32'h1234_0000
  - Each with done one cycle after start, busy=0 throughout.
- ADD wrap: A=32'hFFFF_FFFF, B=1 -> ALUResult=0, Zero=1, invalid_op=0.
- SLL(0110) B=1, shamt=4 -> busy=1 for 4 cycles, then done pulse with ALUResult=32'h10.
- SRL(0111) B=32'h8000_0000, shamt=31 -> ALUResult=1 after 31 cycles. During the run, toggle start and change A/B/ALUOperation -> no effect on result.
- Shift with shamt=0, B=32'hABCD_0000 -> 1-cycle completion with ALUResult=B.
- Invalid code 1001 -> ALUResult=0, invalid_op=1, done pulse.
- Reset mid-shift (shamt=20, assert after 5 cycles) -> returns to IDLE with no done. A following ADD completes normally.
